// File: rtl/disp_pkg.sv
// ============================================================================
// Module  : disp_pkg
// Brief   : Shared types, glyph constants and BCD helper for the display driver
// Revision: 1.0
// ============================================================================
`default_nettype none

package disp_pkg;

    typedef enum logic {
        SLOT_UNITS = 1'b0,
        SLOT_TENS  = 1'b1
    } slot_e;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_OFF = 7'b0000000;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    // Returns {tens, units[3:0]}; input range 0..15 keeps tens at 0 or 1
    function automatic logic [4:0] bin4_to_bcd(input logic [3:0] bin);
        logic tens;
        tens = (bin >= 4'd10);
        return {tens, (tens ? bin - 4'd10 : bin)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_encoder.sv
// ============================================================================
// Module  : seg7_encoder
// Brief   : 4-bit decimal digit to active-high 7-segment pattern
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_encoder
    import disp_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_digit)
            4'd0:    o_seg = SEG_DIGIT[0];
            4'd1:    o_seg = SEG_DIGIT[1];
            4'd2:    o_seg = SEG_DIGIT[2];
            4'd3:    o_seg = SEG_DIGIT[3];
            4'd4:    o_seg = SEG_DIGIT[4];
            4'd5:    o_seg = SEG_DIGIT[5];
            4'd6:    o_seg = SEG_DIGIT[6];
            4'd7:    o_seg = SEG_DIGIT[7];
            4'd8:    o_seg = SEG_DIGIT[8];
            4'd9:    o_seg = SEG_DIGIT[9];
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seq_display_driver.sv
// ============================================================================
// Module  : seq_display_driver
// Brief   : 2-digit multiplexed 7-segment driver for a 0..15 binary value,
//           value sampled once per frame so both digits always agree
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_display_driver
    import disp_pkg::*;
#(
    parameter int CLK_HZ             = 50_000_000,
    parameter int REFRESH_HZ         = 1_000,
    parameter bit SEG_ACTIVE_LOW     = 1'b1,
    parameter bit BLANK_LEADING_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] value_in,
    input  logic       disp_en,
    output logic [6:0] seg_n,
    output logic [1:0] an_n,
    output logic       frame_tick
);

    localparam int            DIV        = CLK_HZ / REFRESH_HZ;
    localparam int            PW         = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [6:0]    SEG_DARK   = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic [1:0]    AN_DARK    = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [PW-1:0] r_presc;
    slot_e         r_slot;
    logic [3:0]    r_shadow;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;
    logic          r_frame_tick;

    logic          w_scan_tick;
    slot_e         w_slot_nxt;
    logic          w_frame_start;
    logic [3:0]    w_shadow_nxt;
    logic [4:0]    w_bcd;
    logic [3:0]    w_digit;
    logic [1:0]    w_an_act;
    logic          w_lit;
    logic [6:0]    w_seg_act;
    logic [6:0]    w_seg_nxt;
    logic [1:0]    w_an_nxt;

    assign w_scan_tick   = (r_presc == PRESC_LAST);
    assign w_frame_start = w_scan_tick && (w_slot_nxt == SLOT_UNITS);
    assign w_shadow_nxt  = w_frame_start ? value_in : r_shadow;
    assign w_bcd         = bin4_to_bcd(w_shadow_nxt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot <= SLOT_TENS;
        end else begin
            r_slot <= w_slot_nxt;
        end
    end

    always_comb begin
        w_slot_nxt = r_slot;
        if (w_scan_tick) begin
            w_slot_nxt = (r_slot == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
        end
    end

    // Outputs are computed from the upcoming slot and shadow so the units
    // digit shows a freshly latched value on the very edge that latches it.
    always_comb begin
        w_digit  = w_bcd[3:0];
        w_an_act = 2'b01;
        w_lit    = disp_en;
        if (w_slot_nxt == SLOT_TENS) begin
            w_digit  = {3'b000, w_bcd[4]};
            w_an_act = 2'b10;
            if (BLANK_LEADING_ZERO && !w_bcd[4]) begin
                w_lit = 1'b0;
            end
        end
    end

    seg7_encoder u_seg7_encoder (
        .i_digit (w_digit),
        .o_seg   (w_seg_act)
    );

    always_comb begin
        w_seg_nxt = SEG_DARK;
        w_an_nxt  = AN_DARK;
        if (w_lit) begin
            w_seg_nxt = SEG_ACTIVE_LOW ? ~w_seg_act : w_seg_act;
            w_an_nxt  = SEG_ACTIVE_LOW ? ~w_an_act  : w_an_act;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc      <= '0;
            r_shadow     <= '0;
            r_seg        <= SEG_DARK;
            r_an         <= AN_DARK;
            r_frame_tick <= 1'b0;
        end else begin
            r_presc      <= w_scan_tick ? '0 : r_presc + 1'b1;
            r_shadow     <= w_shadow_nxt;
            r_frame_tick <= w_frame_start;
            if (w_scan_tick) begin
                r_seg <= w_seg_nxt;
                r_an  <= w_an_nxt;
            end
        end
    end

    assign seg_n      = r_seg;
    assign an_n       = r_an;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire
